// File: rtl/lockin_acumulador.sv
// Dual-phase lock-in demodulator/accumulator.
// Multiplies each sample by sine/cosine references and sums both products
// over N complete periods of M samples. A one-cycle pulse marks the update
// of the in-phase and quadrature window sums.
module lockin_acumulador #(
  parameter int Q_in  = 24,
  parameter int Q_ref = 16,
  parameter int M     = 16,
  parameter int N     = 8,
  parameter int Q_out = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [Q_in-1:0]  data_in,
  input  logic             data_in_valid,
  output logic [Q_out-1:0] data_out_fase,
  output logic [Q_out-1:0] data_out_cuad,
  output logic             data_out_valid,
  output logic             busy
);

  localparam int KW    = $clog2(M);
  localparam int PW    = (N > 1) ? $clog2(N) : 1;
  localparam int PRODW = Q_in + Q_ref;
  localparam int AMP   = 2 ** (Q_ref - 1) - 1;

  // Reject parameter sets that could overflow the accumulator or break the
  // counter wrap logic.
  if (Q_out < Q_in + Q_ref + $clog2(M * N)) begin : g_bad_qout
    $error("lockin_acumulador: Q_out too small for Q_in+Q_ref+log2(M*N)");
  end
  if ((M < 4) || ((M & (M - 1)) != 0)) begin : g_bad_m
    $error("lockin_acumulador: M must be a power of two >= 4");
  end
  if ((N < 1) || ((N & (N - 1)) != 0)) begin : g_bad_n
    $error("lockin_acumulador: N must be a power of two >= 1");
  end

  // Reference table, rounded half away from zero so each period sums to 0.
  function automatic logic [M*Q_ref-1:0] ref_table(input bit use_cos);
    logic [M*Q_ref-1:0] tab;
    real ang;
    real v;
    int  r;
    tab = '0;
    for (int k = 0; k < M; k++) begin
      ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(M);
      v   = real'(AMP) * (use_cos ? $cos(ang) : $sin(ang));
      r   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
      tab[k*Q_ref +: Q_ref] = Q_ref'(r);
    end
    return tab;
  endfunction

  localparam logic [M*Q_ref-1:0] SIN_ROM = ref_table(1'b0);
  localparam logic [M*Q_ref-1:0] COS_ROM = ref_table(1'b1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [PW-1:0]     p_q, p_d;
  logic              accept;
  logic              at_first;
  logic              at_last;

  logic [Q_in-1:0]   s1_x_q, s1_x_d;
  logic [Q_ref-1:0]  s1_sin_q, s1_sin_d;
  logic [Q_ref-1:0]  s1_cos_q, s1_cos_d;
  logic              s1_first_q, s1_first_d;
  logic              s1_last_q, s1_last_d;
  logic              s1_valid_q, s1_valid_d;

  logic [PRODW-1:0]  s2_fase_q, s2_fase_d;
  logic [PRODW-1:0]  s2_cuad_q, s2_cuad_d;
  logic              s2_first_q, s2_first_d;
  logic              s2_last_q, s2_last_d;
  logic              s2_valid_q, s2_valid_d;

  logic [Q_out-1:0]  acc_fase_q, acc_fase_d;
  logic [Q_out-1:0]  acc_cuad_q, acc_cuad_d;
  logic [Q_out-1:0]  out_fase_q, out_fase_d;
  logic [Q_out-1:0]  out_cuad_q, out_cuad_d;
  logic              out_valid_q, out_valid_d;

  assign at_first = (k_q == '0) && (p_q == '0);
  assign at_last  = (k_q == KW'(M - 1)) && (p_q == PW'(N - 1));

  // Window FSM: sample acceptance and period/sample index counters.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    k_d     = k_q;
    p_d     = p_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        k_d = '0;
        p_d = '0;
        if (enable) state_d = S_RUN;
      end
      S_RUN: begin
        if (!enable) begin
          // Abort: partial window and any sample in this cycle are dropped.
          state_d = S_IDLE;
          k_d     = '0;
          p_d     = '0;
        end else if (data_in_valid) begin
          accept = 1'b1;
          if (k_q == KW'(M - 1)) begin
            k_d = '0;
            p_d = (p_q == PW'(N - 1)) ? '0 : p_q + 1'b1;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pipeline next-state: S1 capture, S2 products, S3 accumulate/emit.
  always_comb begin
    logic [PRODW-1:0] x_ext, sin_ext, cos_ext;
    logic [Q_out-1:0] fase_ext, cuad_ext, fase_sum, cuad_sum;
    logic             advance;

    s1_valid_d = accept;
    s1_x_d     = data_in;
    s1_sin_d   = SIN_ROM[k_q*Q_ref +: Q_ref];
    s1_cos_d   = COS_ROM[k_q*Q_ref +: Q_ref];
    s1_first_d = at_first;
    s1_last_d  = at_last;

    // Dropping enable flushes whatever is still in flight.
    s2_valid_d = s1_valid_q & enable;
    x_ext      = PRODW'($signed(s1_x_q));
    sin_ext    = PRODW'($signed(s1_sin_q));
    cos_ext    = PRODW'($signed(s1_cos_q));
    s2_fase_d  = x_ext * sin_ext;
    s2_cuad_d  = x_ext * cos_ext;
    s2_first_d = s1_first_q;
    s2_last_d  = s1_last_q;

    advance  = s2_valid_q & enable;
    fase_ext = {{(Q_out-PRODW){s2_fase_q[PRODW-1]}}, s2_fase_q};
    cuad_ext = {{(Q_out-PRODW){s2_cuad_q[PRODW-1]}}, s2_cuad_q};
    // A first-of-window product loads rather than adds: no clear cycle.
    fase_sum = s2_first_q ? fase_ext : acc_fase_q + fase_ext;
    cuad_sum = s2_first_q ? cuad_ext : acc_cuad_q + cuad_ext;

    acc_fase_d  = advance ? fase_sum : acc_fase_q;
    acc_cuad_d  = advance ? cuad_sum : acc_cuad_q;
    out_valid_d = advance & s2_last_q;
    out_fase_d  = out_valid_d ? fase_sum : out_fase_q;
    out_cuad_d  = out_valid_d ? cuad_sum : out_cuad_q;
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      p_q     <= p_d;
    end
  end

  // Pipeline, accumulator and output registers; reset clears all valids.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_x_q      <= '0;
      s1_sin_q    <= '0;
      s1_cos_q    <= '0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_fase_q   <= '0;
      s2_cuad_q   <= '0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      acc_fase_q  <= '0;
      acc_cuad_q  <= '0;
      out_fase_q  <= '0;
      out_cuad_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_x_q      <= s1_x_d;
      s1_sin_q    <= s1_sin_d;
      s1_cos_q    <= s1_cos_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_valid_q  <= s1_valid_d;
      s2_fase_q   <= s2_fase_d;
      s2_cuad_q   <= s2_cuad_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      s2_valid_q  <= s2_valid_d;
      acc_fase_q  <= acc_fase_d;
      acc_cuad_q  <= acc_cuad_d;
      out_fase_q  <= out_fase_d;
      out_cuad_q  <= out_cuad_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign data_out_fase  = out_fase_q;
  assign data_out_cuad  = out_cuad_q;
  assign data_out_valid = out_valid_q;
  assign busy           = (state_q == S_RUN);

endmodule

// File: tb/tb_lockin_acumulador.sv
// Directed bench for lockin_acumulador (M=16, N=8, Q_ref=16 -> A=32767).
// Reference values used: sin[4]=32767, sin[12]=-32767, cos[0]=32767,
// cos[8]=-32767, sin[2]=cos[2]=round(32767*0.70711)=23170, others as noted.
module tb_lockin_acumulador;

  localparam int M   = 16;
  localparam int N   = 8;
  localparam int WIN = M * N;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [23:0] data_in;
  logic        data_in_valid;
  logic [63:0] data_out_fase;
  logic [63:0] data_out_cuad;
  logic        data_out_valid;
  logic        busy;

  lockin_acumulador #(
    .Q_in(24), .Q_ref(16), .M(M), .N(N), .Q_out(64)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_out_fase (data_out_fase),
    .data_out_cuad (data_out_cuad),
    .data_out_valid(data_out_valid),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse log, sampled on the falling edge.
  int          pulse_cyc[$];
  logic [63:0] pulse_fase[$];
  logic [63:0] pulse_cuad[$];
  always @(negedge clk) begin
    if (data_out_valid === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_fase.push_back(data_out_fase);
      pulse_cuad.push_back(data_out_cuad);
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int last_cap;
  int exp_cyc[$];

  typedef struct {
    string              name;
    int                 k_hot;   // -1: value on every sample
    logic signed [23:0] x;
    int                 nwin;
    logic signed [63:0] exp_fase;
    logic signed [63:0] exp_cuad;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // One clock cycle of stimulus; the sample is captured at the edge.
  task automatic cycle(input logic v, input logic [23:0] x);
    data_in_valid = v;
    data_in       = x;
    @(posedge clk);
    #1;
    if (v) last_cap = cyc;
  endtask

  task automatic run_window(input int k_hot, input logic [23:0] x, input int gap);
    for (int s = 0; s < WIN; s++) begin
      cycle(1'b1, (k_hot < 0 || (s % M) == k_hot) ? x : 24'd0);
      repeat (gap) cycle(1'b0, 24'd0);
    end
    exp_cyc.push_back(last_cap);
  endtask

  task automatic clear_log();
    pulse_cyc.delete();
    pulse_fase.delete();
    pulse_cuad.delete();
    exp_cyc.delete();
  endtask

  // Compare logged pulses against count, values and 3-cycle latency.
  task automatic check_pulses(input string name, input int nexp,
                              input logic [63:0] ef, input logic [63:0] ec);
    check({name, "_npulse"}, 64'(pulse_cyc.size()), 64'(nexp));
    for (int j = 0; j < nexp && j < pulse_cyc.size(); j++) begin
      check($sformatf("%s_fase%0d", name, j), pulse_fase[j], ef);
      check($sformatf("%s_cuad%0d", name, j), pulse_cuad[j], ec);
      // S1, S2 and output registers: pulse visible two edges after capture.
      check($sformatf("%s_lat%0d", name, j), 64'(pulse_cyc[j]), 64'(exp_cyc[j] + 2));
    end
  endtask

  initial begin
    vecs[0] = '{"impulse_k4", 4, 24'sd1000, 1, 64'sd262136000, 64'sd0};
    vecs[1] = '{"dc_2win", -1, 24'sd5000, 2, 64'sd0, 64'sd0};
    vecs[2] = '{"negfs_k0", 0, 24'sh800000, 1, 64'sd0,
                -(64'sd8 * 64'sd8388608 * 64'sd32767)};
    vecs[3] = '{"neg_k8", 8, -24'sd1234, 1, 64'sd0, 64'sd323475824};
    vecs[4] = '{"sin_k12", 12, 24'sd7, 1, -64'sd1834952, 64'sd0};
    vecs[5] = '{"diag_k2", 2, 24'sd100, 1, 64'sd18536000, 64'sd18536000};

    reset_n       = 1'b0;
    enable        = 1'b0;
    data_in       = '0;
    data_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fase", data_out_fase, 64'd0);
    check("rst_cuad", data_out_cuad, 64'd0);
    check("rst_valid", 64'(data_out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    reset_n = 1'b1;
    cycle(1'b0, 24'd0);
    check("idle_busy", 64'(busy), 64'd0);
    enable = 1'b1;
    cycle(1'b0, 24'd0);
    check("run_busy", 64'(busy), 64'd1);

    // Table-driven windows, back to back within each vector.
    for (int i = 0; i < 6; i++) begin
      clear_log();
      for (int w = 0; w < vecs[i].nwin; w++) run_window(vecs[i].k_hot, vecs[i].x, 0);
      repeat (6) cycle(1'b0, 24'd0);
      check_pulses(vecs[i].name, vecs[i].nwin, vecs[i].exp_fase, vecs[i].exp_cuad);
      if (vecs[i].nwin == 2 && pulse_cyc.size() == 2)
        check({vecs[i].name, "_spacing"}, 64'(pulse_cyc[1] - pulse_cyc[0]), 64'(WIN));
    end

    // Abort after 70 samples; the sample in the abort cycle is dropped.
    clear_log();
    for (int s = 0; s < 70; s++) cycle(1'b1, ((s % M) == 4) ? 24'd1000 : 24'd0);
    enable = 1'b0;
    cycle(1'b1, 24'd1000);
    repeat (8) cycle(1'b0, 24'd0);
    check("abort_npulse", 64'(pulse_cyc.size()), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hold_fase", data_out_fase, 64'd18536000);
    check("abort_hold_cuad", data_out_cuad, 64'd18536000);
    enable = 1'b1;
    cycle(1'b0, 24'd0);
    run_window(4, 24'd1000, 0);
    repeat (6) cycle(1'b0, 24'd0);
    check_pulses("reenable", 1, 64'sd262136000, 64'sd0);

    // Sparse samples with reset at sample 50, then a fresh window.
    clear_log();
    for (int s = 0; s < 50; s++) begin
      cycle(1'b1, ((s % M) == 4) ? 24'd1000 : 24'd0);
      repeat (199) cycle(1'b0, 24'd0);
    end
    reset_n = 1'b0;
    cycle(1'b1, 24'd1000);
    check("sprst_fase", data_out_fase, 64'd0);
    check("sprst_cuad", data_out_cuad, 64'd0);
    check("sprst_valid", 64'(data_out_valid), 64'd0);
    check("sprst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    cycle(1'b0, 24'd0);
    check("sprst_run", 64'(busy), 64'd1);
    run_window(4, -24'sd500, 2);
    repeat (6) cycle(1'b0, 24'd0);
    check_pulses("sparse", 1, -64'sd131068000, 64'sd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
